// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, ROM limit, reset PC and skid-buffer entry type for instruction fetch.
package fetch_pkg;
  localparam int ADDR_W = 32;
  localparam int INSTR_W = 32;
  localparam logic [ADDR_W-1:0] ROM_DEPTH = ADDR_W'(1024);
  localparam logic [ADDR_W-1:0] RESET_PC = '0;
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_skid_fifo.sv
// fetch_skid_fifo: 2-entry shift FIFO; entry 0 is always the head so outputs come straight from flops.
module fetch_skid_fifo
  import fetch_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   occ
);
  fetch_entry_t e0_q, e0_d, e1_q, e1_d;
  logic [1:0] occ_q, occ_d, keep;
  logic wr;
  always_comb begin
    keep = occ_q - 2'(pop && occ_q != 2'd0);
    wr = push && !flush;
    occ_d = flush ? 2'd0 : keep + 2'(push);
    e0_d = (wr && keep == 2'd0) ? din : pop ? e1_q : e0_q;
    e1_d = (wr && keep != 2'd0) ? din : e1_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      e0_q <= '0;
      e1_q <= '0;
      occ_q <= 2'd0;
    end else begin
      assert (occ_q <= 2'd2 && !(wr && !pop && occ_q == 2'd2));
      e0_q <= e0_d;
      e1_q <= e1_d;
      occ_q <= occ_d;
    end
  end
  assign head = e0_q;
  assign occ = occ_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner for a synchronous ROM; credits issue against a 2-entry skid buffer.
module instr_fetch_unit
  import fetch_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic [INSTR_W:0]   rom_instruction,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instruction,
  output logic [ADDR_W-1:0]  if_pc,
  output logic               fetch_fault
);
  logic [ADDR_W-1:0] pc_q, pc_d, inflight_pc_q, inflight_pc_d;
  logic inflight_q, inflight_d, fault_q, fault_d;
  logic pop, push, issue, out_of_range, rom_msb_unused;
  logic [1:0] occ;
  logic [2:0] credit;
  fetch_entry_t head, din;
  assign rom_msb_unused = rom_instruction[INSTR_W];
  assign out_of_range = pc_q >= ROM_DEPTH;
  assign pop = if_valid && if_ready;
  // words buffered plus the one in the ROM pipe must never exceed the buffer depth
  assign credit = 3'(occ) + 3'(inflight_q) - 3'(pop);
  assign issue = !reset && !redirect_valid && !fault_q && !out_of_range && credit < 3'd2;
  assign push = inflight_q && !redirect_valid;
  assign din = '{instr: rom_instruction[INSTR_W-1:0], pc: inflight_pc_q};
  always_comb begin
    pc_d = redirect_valid ? redirect_pc : issue ? pc_q + 1'b1 : pc_q;
    inflight_d = issue;
    inflight_pc_d = issue ? pc_q : inflight_pc_q;
    fault_d = redirect_valid ? 1'b0 : fault_q | out_of_range;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      inflight_pc_q <= '0;
      fault_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      inflight_q <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      fault_q <= fault_d;
    end
  end
  fetch_skid_fifo u_skid (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (din),
    .head  (head),
    .occ   (occ)
  );
  assign rom_address = pc_q;
  assign if_valid = occ != 2'd0;
  assign if_instruction = head.instr;
  assign if_pc = head.pc;
  assign fetch_fault = fault_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: random and directed stimulus against a queue-based model of issued-but-unconsumed words.
module tb_instr_fetch_unit;
  logic clock = 1'b0;
  logic reset, redirect_valid, if_ready, if_valid, fetch_fault;
  logic [31:0] rom_address, redirect_pc, if_instruction, if_pc;
  logic [32:0] rom_instruction = '0;
  int total = 0, bad = 0;

  instr_fetch_unit dut (
    .clock          (clock),
    .reset          (reset),
    .rom_address    (rom_address),
    .rom_instruction(rom_instruction),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instruction (if_instruction),
    .if_pc          (if_pc),
    .fetch_fault    (fetch_fault)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a + 32'hA0;
  endfunction

  // synchronous ROM; the spare top bit is noise the DUT must ignore
  always @(posedge clock) rom_instruction <= {1'($urandom), rom_word(rom_address)};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // model: every word issued and not yet consumed or discarded, visible two cycles after issue
  typedef struct {
    logic [31:0] pc;
    int vis;
  } ent_t;
  ent_t q[$];
  logic [31:0] m_pc = '0;
  bit m_fault = 1'b0, armed = 1'b0, ev, oor;
  int mt = 0;

  always @(negedge clock) begin
    ev = armed && q.size() > 0 && q[0].vis <= mt;
    if (armed) begin
      chk("rom_address", rom_address, m_pc);
      chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
      chk("if_valid", 32'(if_valid), 32'(ev));
      if (ev) begin
        chk("if_pc", if_pc, q[0].pc);
        chk("if_instruction", if_instruction, rom_word(q[0].pc));
      end
    end
    if (reset) begin
      q.delete();
      m_pc = '0;
      m_fault = 1'b0;
      armed = 1'b1;
    end else if (armed) begin
      if (ev && if_ready) void'(q.pop_front());
      if (redirect_valid) begin
        q.delete();
        m_pc = redirect_pc;
        m_fault = 1'b0;
      end else begin
        oor = m_pc >= 32'd1024;
        if (!m_fault && !oor && q.size() < 2) begin
          q.push_back('{m_pc, mt + 2});
          m_pc = m_pc + 32'd1;
        end
        if (oor) m_fault = 1'b1;
      end
    end
    mt++;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int r;
    reset = 1'b1; if_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (3) step();
    // reset release, steady stream
    reset = 1'b0;
    chk("rst if_valid", 32'(if_valid), 32'd0);
    chk("rst if_pc", if_pc, 32'd0);
    chk("rst if_instruction", if_instruction, 32'd0);
    chk("rst fetch_fault", 32'(fetch_fault), 32'd0);
    chk("rst rom_address", rom_address, 32'd0);
    step(); chk("c1 if_valid", 32'(if_valid), 32'd0);
    step(); chk("c2 if_valid", 32'(if_valid), 32'd1);
    chk("c2 if_pc", if_pc, 32'd0); chk("c2 instr", if_instruction, 32'hA0);
    step(); chk("c3 if_pc", if_pc, 32'd1);
    step(); chk("c4 if_pc", if_pc, 32'd2);
    step(); chk("c5 if_pc", if_pc, 32'd3);
    // back-pressure
    reset = 1'b1; step(); reset = 1'b0; if_ready = 1'b0;
    step(); step();
    for (int i = 0; i < 5; i++) begin
      chk("bp if_valid", 32'(if_valid), 32'd1);
      chk("bp if_pc", if_pc, 32'd0);
      chk("bp rom_address", rom_address, 32'd2);
      step();
    end
    if_ready = 1'b1;
    chk("bp rel pc0", if_pc, 32'd0);
    step(); chk("bp rel pc1", if_pc, 32'd1);
    step(); chk("bp rel pc2", if_pc, 32'd2);
    step(); chk("bp rel pc3", if_pc, 32'd3);
    // redirect in cycle 6, same cycle as a pop
    reset = 1'b1; step(); reset = 1'b0;
    repeat (6) step();
    chk("c6 head pc4", if_pc, 32'd4);
    redirect_valid = 1'b1; redirect_pc = 32'd8;
    step(); redirect_valid = 1'b0;
    chk("c7 if_valid", 32'(if_valid), 32'd0);
    step(); chk("c8 if_valid", 32'(if_valid), 32'd0); chk("c8 rom_address", rom_address, 32'd9);
    step(); chk("c9 if_valid", 32'(if_valid), 32'd1); chk("c9 if_pc", if_pc, 32'd8);
    chk("c9 instr", if_instruction, 32'hA8);
    step(); chk("c10 if_pc", if_pc, 32'd9);
    step(); chk("c11 if_pc", if_pc, 32'd10);
    // end of ROM
    redirect_valid = 1'b1; redirect_pc = 32'd1022;
    step(); redirect_valid = 1'b0; chk("oor n1 addr", rom_address, 32'd1022);
    step(); step(); chk("oor n3 pc", if_pc, 32'd1022);
    step(); chk("oor n4 pc", if_pc, 32'd1023); chk("oor n4 fault", 32'(fetch_fault), 32'd1);
    chk("oor n4 addr", rom_address, 32'd1024);
    step(); step(); chk("oor n6 valid", 32'(if_valid), 32'd0); chk("oor n6 addr", rom_address, 32'd1024);
    chk("oor n6 fault", 32'(fetch_fault), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'd0;
    step(); redirect_valid = 1'b0;
    chk("clr fault", 32'(fetch_fault), 32'd0); chk("clr addr", rom_address, 32'd0);
    step(); step(); chk("clr pc0", if_pc, 32'd0); chk("clr instr", if_instruction, 32'hA0);
    // reset with full buffer
    redirect_valid = 1'b1; redirect_pc = 32'd20; if_ready = 1'b0;
    step(); redirect_valid = 1'b0;
    repeat (4) step();
    chk("full head", if_pc, 32'd20);
    reset = 1'b1; step(); reset = 1'b0; if_ready = 1'b1;
    chk("mrst r1 valid", 32'(if_valid), 32'd0);
    step(); chk("mrst r2 valid", 32'(if_valid), 32'd0);
    step(); chk("mrst r3 valid", 32'(if_valid), 32'd1); chk("mrst r3 pc", if_pc, 32'd0);
    // random traffic, model-checked every cycle
    for (int i = 0; i < 800; i++) begin
      r = int'($urandom_range(0, 99));
      reset = (r == 0);
      redirect_valid = (r > 0 && r < 6);
      redirect_pc = ($urandom_range(0, 2) == 0) ? 32'(1018 + $urandom_range(0, 8)) : 32'($urandom_range(0, 1023));
      if_ready = $urandom_range(0, 9) < 7;
      step();
    end
    reset = 1'b0; redirect_valid = 1'b0; if_ready = 1'b1;
    repeat (5) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
